// File: rtl/pc_stack_if.sv
// Bus bundle between the control decoder and the PC stack register.
// Carries next-PC control in one direction and PC/RAS status back.
interface pc_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pc_reset_address;
  logic             enable;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  logic             trap;

  modport master (
    output pc_reset_address,
    output enable,
    output op,
    output target,
    input  dout,
    input  ras_top,
    input  count,
    input  full,
    input  empty,
    input  overflow,
    input  underflow,
    input  trap
  );

  modport slave (
    input  pc_reset_address,
    input  enable,
    input  op,
    input  target,
    output dout,
    output ras_top,
    output count,
    output full,
    output empty,
    output overflow,
    output underflow,
    output trap
  );
endinterface

// File: rtl/pc_stack_register.sv
// PC register with return-address stack and op-coded next-PC select.
// Define PC_STACK_TRAP_EN to vector stack faults to TRAP_ADDR.
module pc_stack_register #(
  parameter int             WIDTH     = 16,
  parameter int             DEPTH     = 8,
  parameter int             INC       = 1,
  parameter logic [WIDTH-1:0] TRAP_ADDR = 16'h0004
) (
  input  logic     CLK,
  input  logic     reset,
  pc_stack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_JUMP   = 3'b010,
    OP_BRANCH = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_CLEAR  = 3'b110,
    OP_RSVD   = 3'b111
  } op_e;

  logic [WIDTH-1:0] r_ras [DEPTH];
  logic [WIDTH-1:0] r_pc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_unf;

  op_e              w_op;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_top;
  logic [AW-1:0]    w_top_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_fault;
  logic [WIDTH-1:0] w_call_fault_pc;
  logic [WIDTH-1:0] w_ret_fault_pc;

  assign w_op      = op_e'(bus.op);
  assign w_pc_inc  = r_pc + WIDTH'(INC);
  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_top_idx = AW'(r_cnt - CW'(1));
  assign w_top     = w_empty ? '0
                   : r_ras[w_top_idx];

  assign w_push  = bus.enable
                && (w_op == OP_CALL)
                && !w_full;
  assign w_fault = bus.enable
                && (((w_op == OP_CALL) && w_full)
                 || ((w_op == OP_RET) && w_empty));

`ifdef PC_STACK_TRAP_EN
  logic r_trap;

  assign w_call_fault_pc = TRAP_ADDR;
  assign w_ret_fault_pc  = TRAP_ADDR;

  always_ff @(posedge CLK) begin
    if (reset) r_trap <= 1'b0;
    else       r_trap <= w_fault;
  end

  assign bus.trap = r_trap;
`else
  logic w_unused;

  assign w_call_fault_pc = bus.target;
  assign w_ret_fault_pc  = w_pc_inc;
  assign w_unused        = ^{TRAP_ADDR, w_fault};
  assign bus.trap        = 1'b0;
`endif

  // RAS storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (!reset && w_push)
      r_ras[r_cnt[AW-1:0]] <= w_pc_inc;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_pc  <= bus.pc_reset_address;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (bus.enable) begin
      unique case (w_op)
        OP_INC:    r_pc <= w_pc_inc;
        OP_JUMP:   r_pc <= bus.target;
        OP_BRANCH: r_pc <= r_pc + bus.target;
        OP_CALL: begin
          if (w_full) begin
            r_ovf <= 1'b1;
            r_pc  <= w_call_fault_pc;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            r_pc  <= bus.target;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            r_unf <= 1'b1;
            r_pc  <= w_ret_fault_pc;
          end else begin
            r_cnt <= r_cnt - CW'(1);
            r_pc  <= w_top;
          end
        end
        OP_CLEAR: begin
          r_cnt <= '0;
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
          r_pc  <= w_pc_inc;
        end
        OP_HOLD, OP_RSVD: ;
        default: ;
      endcase
    end
  end

  assign bus.dout      = r_pc;
  assign bus.ras_top   = w_top;
  assign bus.count     = r_cnt;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
endmodule

// File: doc/pc_stack_register.md
# pc_stack_register

Parametrised program-counter register for the stack processor, succeeding the fixed 16-bit enable/set PC register. It adds an internal return-address stack (RAS), an op-coded next-PC selector (hold, increment, jump, relative branch, call, return, clear) and stack-fault detection. It sits between the control decoder and instruction memory; `dout` drives the fetch address.

## Interface
Parameters:
- `WIDTH`, 16, PC and address width in bits.
- `DEPTH`, 8, RAS entries; power of two, ≥ 2.
- `INC`, 1, increment step added by INC, CALL and CLEAR.
- `TRAP_ADDR`, 16'h0004, `WIDTH` bits; fault vector, used only when `PC_STACK_TRAP_EN` is defined.

Ports:
- `CLK` input 1: the single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; sampled on rising `CLK`.
- `pc_reset_address` input `WIDTH`: value loaded into `dout` on reset.
- `enable` input 1: 0 forces HOLD regardless of `op`.
- `op` input 3: next-PC operation.
- `target` input `WIDTH`: jump/call address or signed branch offset.
- `dout` output `WIDTH`: registered current PC.
- `ras_top` output `WIDTH`: top RAS entry; 0 when empty.
- `count` output `$clog2(DEPTH)+1`: number of RAS entries.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `overflow` output 1: sticky; set by CALL when full.
- `underflow` output 1: sticky; set by RET when empty.
- `trap` output 1: one-cycle registered fault pulse; constant 0 unless `PC_STACK_TRAP_EN`.

## Operation
- Reset has priority over all ops:
  - `dout <= pc_reset_address`.
  - `count`, `overflow`, `underflow` and `trap` go to 0.
  - RAS contents are don't-care; `ras_top` reads 0 because the stack is empty.
- Op encoding, applied when `enable` = 1:
  - 000 HOLD: no change.
  - 001 INC: `dout <= dout + INC`.
  - 010 JUMP: `dout <= target`.
  - 011 BRANCH: `dout <= dout + target`.
  - 100 CALL: push `dout + INC`, `count++`, `dout <= target`.
  - 101 RET: `dout <=` top entry, `count--`.
  - 110 CLEAR: `count <= 0`, clear `overflow`/`underflow`, `dout <= dout + INC`.
  - 111: reserved, behaves as HOLD.
- Arithmetic is modulo 2^`WIDTH`; wrap-around is silent, with no flag. BRANCH treats `target` as two's complement.
- CALL when `full`:
  - Push is discarded and `count` is unchanged.
  - `overflow` is set.
  - `dout <= target` (trap variant: see Configuration).
- RET when `empty`:
  - `count` stays 0.
  - `underflow` is set.
  - `dout <= dout + INC` (trap variant: see Configuration).
- Sticky flags clear only on reset or CLEAR.
- `trap` deasserts on the cycle after it is set unless a new fault occurs.
- `ras_top` is a combinational read of entry `count-1` from registered state, so it is stable for the whole cycle.

## Timing
- Latency is one cycle: an op sampled at edge N is visible on `dout`/`count`/flags after edge N.
- `full`/`empty` are derived from `count`, so they change in the same cycle.
- Back-to-back CALL/RET on consecutive cycles is supported. A RET immediately after a CALL returns the just-pushed `dout+INC`.
- Reset asserted mid-sequence (e.g. the cycle of a CALL) wins; the push is lost.
- No handshake is involved: the caller must hold `op`/`target` valid at the sampling edge.

## Configuration
- `PC_STACK_TRAP_EN` defined:
  - CALL-when-full and RET-when-empty load `dout <= TRAP_ADDR` and pulse `trap` for one cycle.
  - The sticky flag still sets.
  - Stack state is unchanged.
- `PC_STACK_TRAP_EN` undefined:
  - Fault behaviour is exactly as in Operation.
  - `trap` is tied to 0.
  - `TRAP_ADDR` is unused.

## Test plan
Parameters for all scenarios: `WIDTH`=16, `DEPTH`=4, `INC`=1.
- Reset: `pc_reset_address`=16'h0100, `reset`=1 for one edge -> `dout`=0100, `count`=0, `empty`=1, all flags 0; with `reset`=0, changing `pc_reset_address` has no effect.
- INC, BRANCH and wrap:
  - Reset to FFFE, then INC ×2 -> `dout`=FFFF, then 0000.
  - BRANCH `target`=FFFD (-3) from 0010 -> 000D.
  - INC with `enable`=0 -> `dout` holds.
- Nested calls: from 0100, CALL 0200, CALL 0300 -> `count`=2, `ras_top`=0201; RET -> `dout`=0201; RET -> `dout`=0101, `empty`=1.
- Overflow: 5 CALLs from 0000 with `target`=0010..0050 -> `full` after the 4th; the 5th leaves `count`=4 and sets `overflow`=1; `dout`=0050 without the macro, 0004 with `trap` pulsed for 1 cycle with the macro.
- Underflow and clear: RET on empty at 0020 -> `underflow`=1, `dout`=0021 (or 0004 + `trap` with the macro); CLEAR -> flags 0, `count`=0, `dout` increments.
- Reset mid-CALL: `reset` and `op`=CALL in the same cycle -> `dout`=`pc_reset_address`, `count`=0.
